// File: rtl/jtag_gpr_access.sv
// Debug-side JTAG initiator for the GPR file: retries writes blocked by core writes, with timeout.
// Optional readback check of landed writes is enabled by defining JTAG_GPR_READBACK_EN.
module jtag_gpr_access #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    input  logic              core_we_i,
    output logic              jtag_we_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [DATA_W-1:0] jtag_data_o,
    input  logic [DATA_W-1:0] jtag_data_i
);

    localparam int unsigned RetryW = $clog2(RETRY_MAX + 1);

`ifdef JTAG_GPR_READBACK_EN
    typedef enum logic [2:0] {StIdle, StWrite, StRead, StVerify, StResp} state_e;
`else
    typedef enum logic [2:0] {StIdle, StWrite, StRead, StResp} state_e;
`endif

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                jtag_we_q, jtag_we_d;
    logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
    logic [DATA_W-1:0]   jtag_data_q, jtag_data_d;
    logic [RetryW-1:0]   retry_q, retry_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        jtag_we_d   = jtag_we_q;
        jtag_addr_d = jtag_addr_q;
        jtag_data_d = jtag_data_q;
        retry_d     = retry_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                // cmd_ready_q is low for the first cycle after reset, so nothing is accepted then
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    jtag_addr_d = cmd_addr_i;
                    jtag_data_d = cmd_wdata_i;
                    retry_d     = '0;
                    if (cmd_we_i) begin
                        state_d   = StWrite;
                        jtag_we_d = 1'b1;
                    end else begin
                        state_d   = StRead;
                        jtag_we_d = 1'b0;
                    end
                end
            end
            StWrite: begin
                if (!core_we_i) begin
                    // No core write this cycle, so the GPR file takes the JTAG write at this edge
                    jtag_we_d   = 1'b0;
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
`ifdef JTAG_GPR_READBACK_EN
                    if (jtag_addr_q != '0) begin
                        state_d     = StVerify;
                        rsp_valid_d = 1'b0;
                    end
`endif
                end else begin
                    retry_d = retry_q + RetryW'(1);
                    if (retry_d == RetryW'(RETRY_MAX)) begin
                        jtag_we_d   = 1'b0;
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            StRead: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = (jtag_addr_q == '0) ? '0 : jtag_data_i;
            end
`ifdef JTAG_GPR_READBACK_EN
            StVerify: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_err_d   = (jtag_data_i != jtag_data_q);
                rsp_rdata_d = (jtag_data_i != jtag_data_q) ? jtag_data_i : '0;
            end
`endif
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            jtag_we_q   <= 1'b0;
            jtag_addr_q <= '0;
            jtag_data_q <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            jtag_we_q   <= jtag_we_d;
            jtag_addr_q <= jtag_addr_d;
            jtag_data_q <= jtag_data_d;
            retry_q     <= retry_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign jtag_we_o   = jtag_we_q;
    assign jtag_addr_o = jtag_addr_q;
    assign jtag_data_o = jtag_data_q;

endmodule

// File: tb/tb_jtag_gpr_access.sv
// Bench for jtag_gpr_access: GPR file model with core-write priority plus a command-level
// reference memory; directed cases followed by randomized commands.
module tb_jtag_gpr_access;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned RM = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic          jtag_we;
    logic [AW-1:0] jtag_addr;
    logic [DW-1:0] jtag_wdata, jtag_rdata;

    logic [DW-1:0] gpr     [32];
    logic [DW-1:0] ref_mem [32];

    int n_cmp = 0;
    int n_err = 0;

    jtag_gpr_access #(.ADDR_W(AW), .DATA_W(DW), .RETRY_MAX(RM)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .core_we_i   (core_we),
        .jtag_we_o   (jtag_we),
        .jtag_addr_o (jtag_addr),
        .jtag_data_o (jtag_wdata),
        .jtag_data_i (jtag_rdata)
    );

    always #5 clk = ~clk;

    // GPR file: core write port wins, a coincident JTAG write is dropped
    always @(posedge clk) begin
        if (core_we) gpr[core_addr] <= core_data;
        else if (jtag_we && jtag_addr != '0) gpr[jtag_addr] <= jtag_wdata;
    end
    assign jtag_rdata = (jtag_addr == '0) ? '0 : gpr[jtag_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command; b = cycles core_we is held high after accept; hold = rsp stall cycles
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int b, input int hold);
        int            lat, we_cyc, exp_lat, exp_we;
        logic          exp_err, landed;
        logic [DW-1:0] exp_rd, rd0;
        logic          err0;
        for (int i = 0; i < 4 && !cmd_ready; i++) tick();
        check("cmd_ready_idle", cmd_ready, 1);
        exp_rd = (addr == '0) ? '0 : ref_mem[addr];
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
        lat = 0; we_cyc = 0;
        while (!rsp_valid && lat < 40) begin
            we_cyc += int'(jtag_we);
            core_we   = (lat < b);
            core_addr = AW'($urandom_range(1, 31));
            core_data = $urandom;
            if (core_we) ref_mem[core_addr] = core_data;
            tick();
            lat++;
        end
        core_we = 1'b0;
        if (we) begin
            landed  = (b < RM);
            exp_lat = landed ? b + 2 : RM + 1;
`ifdef JTAG_GPR_READBACK_EN
            if (landed && addr != '0) exp_lat++;
`endif
            exp_we  = landed ? b + 1 : RM;
            exp_err = !landed;
            exp_rd  = '0;
            if (landed && addr != '0) ref_mem[addr] = wdata;
        end else begin
            exp_lat = 2;
            exp_we  = 0;
            exp_err = 1'b0;
        end
        check("rsp_valid", rsp_valid, 1);
        check("latency", 32'(lat + 1), 32'(exp_lat));
        check("jtag_we_cycles", 32'(we_cyc), 32'(exp_we));
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        rd0 = rsp_rdata; err0 = rsp_err;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, rd0);
            check("hold_err", rsp_err, err0);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            gpr[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; core_we = 1'b0; core_addr = 5'd1; core_data = '0;
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_jtag_we", jtag_we, 0);
        check("rst_jtag_addr", 32'(jtag_addr), 0);
        check("rst_jtag_data", jtag_wdata, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        run_cmd(1'b1, 5'd5, 32'hDEADBEEF, 0, 0);
        run_cmd(1'b0, 5'd5, '0, 0, 0);
        run_cmd(1'b1, 5'd7, 32'h0000_1234, 3, 1);
        run_cmd(1'b0, 5'd7, '0, 0, 0);
        run_cmd(1'b1, 5'd7, 32'hCAFE_F00D, 40, 0);
        run_cmd(1'b0, 5'd7, '0, 0, 0);
        run_cmd(1'b1, 5'd0, 32'hFFFF_FFFF, 0, 0);
        run_cmd(1'b0, 5'd0, '0, 0, 0);
        run_cmd(1'b0, 5'd5, '0, 2, 5);
        run_cmd(1'b1, 5'd8, 32'h0BAD_0001, RM - 1, 0);

        // Reset in the middle of a blocked write, with a command offered alongside reset
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'h5555_AAAA;
        tick();
        cmd_valid = 1'b0;
        core_we = 1'b1; core_addr = 5'd3; core_data = 32'h0303_0303;
        ref_mem[3] = core_data;
        tick();
        tick();
        check("mid_write_we", jtag_we, 1);
        rst = 1'b1; cmd_valid = 1'b1;
        tick();
        check("rst_write_we", jtag_we, 0);
        check("rst_write_valid", rsp_valid, 0);
        check("rst_write_ready", cmd_ready, 0);
        rst = 1'b0; cmd_valid = 1'b0; core_we = 1'b0;
        tick();
        check("after_rst_ready", cmd_ready, 1);
        check("after_rst_valid", rsp_valid, 0);
        check("after_rst_we", jtag_we, 0);
        run_cmd(1'b0, 5'd9, '0, 0, 0);
        run_cmd(1'b0, 5'd3, '0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic          rw;
            logic [AW-1:0] a;
            int            blk;
            rw  = 1'($urandom_range(0, 1));
            a   = AW'($urandom_range(0, 31));
            blk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(RM - 1, RM + 3))
                                              : int'($urandom_range(0, 4));
            run_cmd(rw, a, $urandom, blk, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
